// File: rtl/multitap.sv
`default_nettype none
// ============================================================================
// Module   : multitap
// Purpose  : Pad multiplexer answering the host TH/TR handshake with a
//            nibble-serial frame of pad types followed by button data.
//            Define MULTITAP_TIMEOUT_EN to build the idle-rewind counter.
// Revision : 1.0 - initial release
// ============================================================================
module multitap #(
    parameter int NUM_PADS       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       port_sel,
    input  logic [(NUM_PADS+1)*12-1:0] pads,
    input  logic [NUM_PADS:0]          pad_6btn,
    input  logic [NUM_PADS:0]          pad_present,
    input  logic [6:0]                 port1_in,
    input  logic [6:0]                 port1_dir,
    output logic [6:0]                 port1_out,
    input  logic [6:0]                 port2_in,
    input  logic [6:0]                 port2_dir,
    output logic [6:0]                 port2_out
);

    localparam logic [5:0] c_idx_data0 = 6'(4 + NUM_PADS);
    localparam logic [5:0] c_idx_max   = 6'd63;
    localparam logic [3:0] c_ptr_done  = 4'(NUM_PADS);
    localparam logic [6:0] c_out_rst   = 7'h73;

    if (NUM_PADS < 1 || NUM_PADS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("multitap: NUM_PADS must be 1..8 and TIMEOUT_CYCLES 1..65535");
    end

    logic [1:0]             hs_d,        hs_q;
    logic                   sel_d,       sel_q;
    logic [5:0]             idx_d,       idx_q;
    logic [3:0]             ptr_d,       ptr_q;
    logic [1:0]             sub_d,       sub_q;
    logic [NUM_PADS*12-1:0] snap_btn_d,  snap_btn_q;
    logic [NUM_PADS-1:0]    snap_6_d,    snap_6_q;
    logic [NUM_PADS-1:0]    snap_pres_d, snap_pres_q;
    logic [6:0]             out_d,       out_q;

    logic                   w_th_rise;
    logic                   w_hs_change;
    logic                   w_restart;
    logic                   w_rewind;
    logic [NUM_PADS*12-1:0] w_pick_btn;
    logic [NUM_PADS-1:0]    w_pick_6;
    logic [NUM_PADS-1:0]    w_pick_pres;
    logic [3:0]             w_first_pad;
    logic [3:0]             w_next_pad;
    logic                   w_last_sub;
    logic [3:0]             w_nibble;

    assign hs_d  = port_sel ? (port2_in[6:5] | port2_dir[6:5])
                            : (port1_in[6:5] | port1_dir[6:5]);
    assign sel_d = port_sel;

    assign w_th_rise   = ~hs_q[1] & hs_d[1];
    assign w_hs_change = (hs_d != hs_q);
    // Switching the tapped port restarts the frame exactly like a TH rise.
    assign w_restart   = w_th_rise | (port_sel != sel_q);

    always_comb begin
        if (port_sel) begin
            w_pick_btn  = pads[(NUM_PADS+1)*12-1:12];
            w_pick_6    = pad_6btn[NUM_PADS:1];
            w_pick_pres = pad_present[NUM_PADS:1];
        end else begin
            w_pick_btn  = pads[NUM_PADS*12-1:0];
            w_pick_6    = pad_6btn[NUM_PADS-1:0];
            w_pick_pres = pad_present[NUM_PADS-1:0];
        end
    end

`ifdef MULTITAP_TIMEOUT_EN
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_d, idle_q;

    // The counter parks at the limit so one idle period rewinds only once.
    always_comb begin
        idle_d = idle_q;
        if (w_hs_change) begin
            idle_d = '0;
        end else if (idle_q != c_timeout) begin
            idle_d = idle_q + 16'd1;
        end
    end

    assign w_rewind = ~w_hs_change & (idle_q != c_timeout) & (idle_d == c_timeout);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign w_rewind = 1'b0;
`endif

    // Lowest present pad overall, and lowest present pad above the pointer.
    always_comb begin
        w_first_pad = c_ptr_done;
        w_next_pad  = c_ptr_done;
        for (int k = NUM_PADS - 1; k >= 0; k--) begin
            if (snap_pres_q[k]) begin
                w_first_pad = 4'(k);
                if (4'(k) > ptr_q) begin
                    w_next_pad = 4'(k);
                end
            end
        end
    end

    always_comb begin
        w_last_sub = 1'b1;
        for (int k = 0; k < NUM_PADS; k++) begin
            if (ptr_q == 4'(k)) begin
                w_last_sub = snap_6_q[k] ? (sub_q == 2'd2) : (sub_q == 2'd1);
            end
        end
    end

    always_comb begin
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        sub_d       = sub_q;
        snap_btn_d  = snap_btn_q;
        snap_6_d    = snap_6_q;
        snap_pres_d = snap_pres_q;
        if (w_restart) begin
            idx_d       = '0;
            ptr_d       = '0;
            sub_d       = '0;
            snap_btn_d  = w_pick_btn;
            snap_6_d    = w_pick_6;
            snap_pres_d = w_pick_pres;
        end else if (w_hs_change) begin
            if (idx_q != c_idx_max) begin
                idx_d = idx_q + 6'd1;
                if (idx_q == c_idx_data0 - 6'd1) begin
                    ptr_d = w_first_pad;
                    sub_d = '0;
                end else if (idx_q >= c_idx_data0 && ptr_q != c_ptr_done) begin
                    if (w_last_sub) begin
                        ptr_d = w_next_pad;
                        sub_d = '0;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
            end
        end else if (w_rewind) begin
            idx_d = '0;
            ptr_d = '0;
            sub_d = '0;
        end
    end

    always_comb begin
        w_nibble = 4'hF;
        if (idx_q == 6'd0) begin
            w_nibble = 4'h3;
        end else if (idx_q == 6'd1) begin
            w_nibble = 4'hF;
        end else if (idx_q == 6'd2 || idx_q == 6'd3) begin
            w_nibble = 4'h0;
        end else if (idx_q < c_idx_data0) begin
            for (int k = 0; k < NUM_PADS; k++) begin
                if (idx_q == 6'(4 + k)) begin
                    w_nibble = !snap_pres_q[k] ? 4'hF : (snap_6_q[k] ? 4'h1 : 4'h0);
                end
            end
        end else begin
            for (int k = 0; k < NUM_PADS; k++) begin
                if (ptr_q == 4'(k)) begin
                    case (sub_q)
                        2'd0:    w_nibble = ~snap_btn_q[k*12 +: 4];
                        2'd1:    w_nibble = ~snap_btn_q[k*12 + 4 +: 4];
                        default: w_nibble = ~snap_btn_q[k*12 + 8 +: 4];
                    endcase
                end
            end
        end
    end

    // TL mirrors TR as the acknowledge back to the host.
    assign out_d = {hs_q[1], hs_q[0], hs_q[0], w_nibble};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q        <= 2'b11;
            sel_q       <= 1'b0;
            idx_q       <= '0;
            ptr_q       <= '0;
            sub_q       <= '0;
            snap_btn_q  <= '0;
            snap_6_q    <= '0;
            snap_pres_q <= '0;
            out_q       <= c_out_rst;
        end else begin
            hs_q        <= hs_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            sub_q       <= sub_d;
            snap_btn_q  <= snap_btn_d;
            snap_6_q    <= snap_6_d;
            snap_pres_q <= snap_pres_d;
            out_q       <= out_d;
        end
    end

    assign port1_out = (~port1_dir & port1_in) | (port1_dir & out_q);
    assign port2_out = (~port2_dir & port2_in) | (port2_dir & out_q);

endmodule
`default_nettype wire

// File: tb/tb_multitap.sv
`default_nettype none
// ============================================================================
// Module   : tb_multitap
// Purpose  : Self-checking bench for multitap against a frame-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multitap;

    localparam int NP = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 port_sel;
    logic [(NP+1)*12-1:0] pads;
    logic [NP:0]          pad_6btn;
    logic [NP:0]          pad_present;
    logic [6:0]           port1_in, port1_dir, port1_out;
    logic [6:0]           port2_in, port2_dir, port2_out;

    multitap #(.NUM_PADS(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .port_sel    (port_sel),
        .pads        (pads),
        .pad_6btn    (pad_6btn),
        .pad_present (pad_present),
        .port1_in    (port1_in),
        .port1_dir   (port1_dir),
        .port1_out   (port1_out),
        .port2_in    (port2_in),
        .port2_dir   (port2_dir),
        .port2_out   (port2_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the whole frame as a list of nibbles plus a position.
    logic [3:0] m_frame[$];
    int         m_idx;
    logic       m_th, m_tr;
    logic [4:0] tap_in_lo, tap_dir_lo;
    logic [6:0] oth_in, oth_dir;

    function automatic void build_frame();
        int base;
        logic [11:0] b;
        logic [3:0]  nb;
        base = port_sel ? 1 : 0;
        m_frame.delete();
        m_frame.push_back(4'h3);
        m_frame.push_back(4'hF);
        m_frame.push_back(4'h0);
        m_frame.push_back(4'h0);
        for (int k = 0; k < NP; k++) begin
            if (!pad_present[base+k]) m_frame.push_back(4'hF);
            else if (pad_6btn[base+k]) m_frame.push_back(4'h1);
            else m_frame.push_back(4'h0);
        end
        for (int k = 0; k < NP; k++) begin
            if (pad_present[base+k]) begin
                b  = pads[(base+k)*12 +: 12];
                nb = ~b[3:0];  m_frame.push_back(nb);
                nb = ~b[7:4];  m_frame.push_back(nb);
                if (pad_6btn[base+k]) begin
                    nb = ~b[11:8]; m_frame.push_back(nb);
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_frame.delete();
        m_frame.push_back(4'h3);
        m_frame.push_back(4'hF);
        m_frame.push_back(4'h0);
        m_frame.push_back(4'h0);
        for (int k = 0; k < NP; k++) m_frame.push_back(4'hF);
        m_idx = 0;
        m_th  = 1'b1;
        m_tr  = 1'b1;
    endfunction

    function automatic logic [3:0] m_nib();
        if (m_idx < m_frame.size()) return m_frame[m_idx];
        return 4'hF;
    endfunction

    function automatic logic [6:0] m_out();
        return {m_th, m_tr, m_tr, m_nib()};
    endfunction

    function automatic logic [6:0] exp_p1();
        return (~port1_dir & port1_in) | (port1_dir & m_out());
    endfunction

    function automatic logic [6:0] exp_p2();
        return (~port2_dir & port2_in) | (port2_dir & m_out());
    endfunction

    function automatic logic [3:0] tap_nib();
        return port_sel ? port2_out[3:0] : port1_out[3:0];
    endfunction

    task automatic drive_ports();
        logic [6:0] t_in, t_dir;
        t_in  = {m_th, m_tr, tap_in_lo};
        t_dir = {2'b00, tap_dir_lo};
        if (port_sel) begin
            port2_in = t_in;   port2_dir = t_dir;
            port1_in = oth_in; port1_dir = oth_dir;
        end else begin
            port1_in = t_in;   port1_dir = t_dir;
            port2_in = oth_in; port2_dir = oth_dir;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_hs(input logic th, input logic tr);
        if (!m_th && th) begin
            m_idx = 0;
            build_frame();
        end else if (th != m_th || tr != m_tr) begin
            if (m_idx < 63) m_idx++;
        end
        m_th = th;
        m_tr = tr;
        drive_ports();
        settle();
    endtask

    task automatic set_sel(input logic v);
        if (port_sel !== v) begin
            port_sel = v;
            m_idx = 0;
            build_frame();
        end
        drive_ports();
        settle();
    endtask

    task automatic start_frame();
        if (m_th) set_hs(1'b0, m_tr);
        set_hs(1'b1, m_tr);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        port_sel    = 1'b0;
        pads        = '0;
        pad_6btn    = '0;
        pad_present = '1;
        tap_in_lo   = 5'($urandom);
        tap_dir_lo  = 5'h1F;
        oth_in      = 7'($urandom);
        oth_dir     = 7'h7F;
        model_reset();
        drive_ports();
        settle();
        n_vec++;
        if (port1_out !== 7'h73) begin
            n_err++;
            $display("FAIL reset_port1: got %h expected %h", port1_out, 7'h73);
        end
        n_vec++;
        if (port2_out !== 7'h73) begin
            n_err++;
            $display("FAIL reset_port2: got %h expected %h", port2_out, 7'h73);
        end
        reset_n = 1'b1;
        settle();
        n_vec++;
        if (port1_out !== 7'h73) begin
            n_err++;
            $display("FAIL post_reset_idle: got %h expected %h", port1_out, 7'h73);
        end
        // Without a TH rise the reset snapshot (all absent) must be served.
        for (int i = 1; i <= 4 + NP; i++) begin
            set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port1_out[3:0] !== ((i == 1) ? 4'hF : (i < 4) ? 4'h0 : 4'hF)) begin
                n_err++;
                $display("FAIL reset_snapshot idx=%0d: got %h expected %h", i, port1_out[3:0],
                         (i == 1) ? 4'hF : (i < 4) ? 4'h0 : 4'hF);
            end
        end
    endtask

    task automatic test_frame_basic();
        logic [3:0] want [13] = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        set_sel(1'b0);
        pads = '0; pad_6btn = '0; pad_present = '1;
        tap_dir_lo = 5'h1F; oth_in = 7'($urandom); oth_dir = 7'($urandom);
        drive_ports();
        start_frame();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port1_out[3:0] !== want[i]) begin
                n_err++;
                $display("FAIL basic_nibble idx=%0d: got %h expected %h", i, port1_out[3:0], want[i]);
            end
            n_vec++;
            if (port1_out[4] !== m_tr) begin
                n_err++;
                $display("FAIL basic_tl_ack idx=%0d: got %b expected %b", i, port1_out[4], m_tr);
            end
        end
    endtask

    task automatic test_mixed();
        logic [3:0] want [18] = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h0, 4'hF,
                                  4'hF, 4'hF, 4'hB, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        set_sel(1'b0);
        pads = '0;
        pads[12 +: 12] = 12'h140;
        pads[24 +: 12] = 12'($urandom);
        pads[48 +: 12] = 12'($urandom);
        pad_6btn    = 5'b00010;
        pad_present = 5'b11011;
        tap_dir_lo  = 5'h1F;
        drive_ports();
        start_frame();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port1_out[3:0] !== want[i]) begin
                n_err++;
                $display("FAIL mixed_nibble idx=%0d: got %h expected %h", i, port1_out[3:0], want[i]);
            end
        end
    endtask

    task automatic test_port2();
        logic [3:0] want [16] = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                  4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hF};
        pads = '0;
        pads[0 +: 12]  = 12'($urandom);
        pads[48 +: 12] = 12'h001;
        pad_6btn    = 5'b00000;
        pad_present = 5'b11110;
        tap_dir_lo  = 5'h1F;
        oth_in      = 7'($urandom);
        oth_dir     = 7'($urandom);
        set_sel(1'b1);
        start_frame();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port2_out[3:0] !== want[i]) begin
                n_err++;
                $display("FAIL port2_nibble idx=%0d: got %h expected %h", i, port2_out[3:0], want[i]);
            end
        end
        n_vec++;
        if ((port1_out & ~port1_dir) !== (port1_in & ~port1_dir)) begin
            n_err++;
            $display("FAIL port1_passthru: got %h expected %h", port1_out & ~port1_dir,
                     port1_in & ~port1_dir);
        end
        n_vec++;
        if (port1_out !== exp_p1()) begin
            n_err++;
            $display("FAIL port1_untapped: got %h expected %h", port1_out, exp_p1());
        end
    endtask

    task automatic test_overrun();
        pads = {(NP+1){12'h000}};
        pad_6btn = '0; pad_present = '1; tap_dir_lo = 5'h1F;
        set_sel(1'b0);
        start_frame();
        for (int i = 1; i <= 20; i++) begin
            set_hs(1'b1, ~m_tr);
            if (i >= 16) begin
                n_vec++;
                if (port1_out[3:0] !== 4'hF) begin
                    n_err++;
                    $display("FAIL overrun idx=%0d: got %h expected %h", i, port1_out[3:0], 4'hF);
                end
            end
        end
        set_hs(1'b0, m_tr);
        set_hs(1'b1, m_tr);
        n_vec++;
        if (port1_out[3:0] !== 4'h3) begin
            n_err++;
            $display("FAIL overrun_restart: got %h expected %h", port1_out[3:0], 4'h3);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] want_late;
        pads = '0; pad_6btn = 5'b00100; pad_present = '1; tap_dir_lo = 5'h1F;
        set_sel(1'b0);
        start_frame();
        repeat (6) set_hs(1'b1, ~m_tr);
        n_vec++;
        if (port1_out[3:0] !== 4'h1) begin
            n_err++;
            $display("FAIL timeout_idx6: got %h expected %h", port1_out[3:0], 4'h1);
        end
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (port1_out[3:0] !== 4'h1) begin
            n_err++;
            $display("FAIL timeout_early: got %h expected %h", port1_out[3:0], 4'h1);
        end
        repeat (14) @(posedge clk);
        #1;
`ifdef MULTITAP_TIMEOUT_EN
        want_late = 4'h3;
        m_idx = 0;
`else
        want_late = 4'h1;
`endif
        n_vec++;
        if (port1_out[3:0] !== want_late) begin
            n_err++;
            $display("FAIL timeout_late: got %h expected %h", port1_out[3:0], want_late);
        end
    endtask

    task automatic test_sel_switch();
        pads = {(NP+1){12'($urandom)}};
        pad_6btn = 5'($urandom); pad_present = 5'($urandom); tap_dir_lo = 5'h1F;
        set_sel(1'b0);
        start_frame();
        repeat (7) set_hs(1'b1, ~m_tr);
        set_sel(1'b1);
        n_vec++;
        if (port2_out[3:0] !== 4'h3) begin
            n_err++;
            $display("FAIL sel_switch_restart: got %h expected %h", port2_out[3:0], 4'h3);
        end
        for (int i = 1; i <= 4 + 3 * NP; i++) begin
            set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port2_out !== exp_p2()) begin
                n_err++;
                $display("FAIL sel_switch_walk idx=%0d: got %h expected %h", i, port2_out, exp_p2());
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            pads        = {(NP+1){12'($urandom)}} ^ (NP+1)*12'($urandom);
            pad_6btn    = 5'($urandom);
            pad_present = 5'($urandom);
            tap_in_lo   = 5'($urandom);
            tap_dir_lo  = 5'($urandom);
            oth_in      = 7'($urandom);
            oth_dir     = 7'($urandom);
            if ($urandom_range(0, 3) == 0) set_sel(~port_sel);
            else begin
                drive_ports();
                settle();
            end
            start_frame();
            pads = {(NP+1){12'($urandom)}};
            pad_present = 5'($urandom);
            for (int s = 0; s < 40; s++) begin
                if ($urandom_range(0, 5) == 0) set_hs(1'($urandom), 1'($urandom));
                else set_hs(m_th, ~m_tr);
                n_vec++;
                if (port1_out !== exp_p1()) begin
                    n_err++;
                    $display("FAIL rand_port1 f=%0d s=%0d: got %h expected %h", f, s, port1_out, exp_p1());
                end
                n_vec++;
                if (port2_out !== exp_p2()) begin
                    n_err++;
                    $display("FAIL rand_port2 f=%0d s=%0d: got %h expected %h", f, s, port2_out, exp_p2());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pads = '0; pad_6btn = '0; pad_present = '1;
        tap_dir_lo = 5'h1F; oth_dir = 7'h7F; oth_in = 7'($urandom);
        set_sel(1'b0);
        start_frame();
        repeat (9) set_hs(1'b1, ~m_tr);
        n_vec++;
        if (port1_out[3:0] !== 4'hF) begin
            n_err++;
            $display("FAIL reset_mid_idx9: got %h expected %h", port1_out[3:0], 4'hF);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ((port1_out & port1_dir) !== (7'h73 & port1_dir)) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h expected %h", port1_out & port1_dir, 7'h73 & port1_dir);
        end
        n_vec++;
        if (port2_out !== 7'h73) begin
            n_err++;
            $display("FAIL reset_mid_port2: got %h expected %h", port2_out, 7'h73);
        end
        model_reset();
        drive_ports();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        settle();
        start_frame();
        for (int i = 1; i <= 6; i++) begin
            set_hs(1'b1, ~m_tr);
            n_vec++;
            if (port1_out[3:0] !== ((i == 1) ? 4'hF : 4'h0)) begin
                n_err++;
                $display("FAIL reset_mid_restart idx=%0d: got %h expected %h", i, port1_out[3:0],
                         (i == 1) ? 4'hF : 4'h0);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame_basic();
        test_mixed();
        test_port2();
        test_overrun();
        test_timeout();
        test_sel_switch();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multitap.md
MULTITAP -- requirements
Module: multitap

Interface
Parameters:
REQ-001 SHALL have parameter NUM_PADS, default 4, number of tapped pads, legal 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, idle clk cycles before the sequencer rewinds to nibble 0.
Ports (name, direction, width, meaning):
REQ-003 SHALL have clk, input, 1, sole clock.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port_sel, input, 1: 0 = tap on port1, pads from slot 0; 1 = tap on port2, pads from slot 1 (slot 0 is the direct pad on port1).
REQ-006 SHALL have pads, input, (NUM_PADS+1)*12, active-high buttons, 12 bits per slot: [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]B [5]C [6]A [7]START [8]Z [9]Y [10]X [11]MODE.
REQ-007 SHALL have pad_6btn, input, NUM_PADS+1, per slot: 1 = 6-button, 0 = 3-button.
REQ-008 SHALL have pad_present, input, NUM_PADS+1, per slot: 1 = connected.
REQ-009 SHALL have port1_in / port1_dir / port1_out, input/input/output, 7 each: pin levels from host, host direction (1 = host drives), value returned to host.
REQ-010 SHALL have port2_in / port2_dir / port2_out, identical for port2.

Function
REQ-011 Bits map as [6]TH, [5]TR, [4]TL, [3:0]D; tapped port = port_sel ? port2 : port1.
REQ-012 Handshake hs[1:0] = tapped {in[6:5] | dir[6:5]}; hs_q registers it each clk.
REQ-013 Index idx (6 bits): rising TH (hs_q[1]=0, hs[1]=1) -> idx=0, taking priority; other change of hs -> idx+1, saturating at 63; no change -> hold.
REQ-014 Nibble sequence by idx: 0 -> 0x3; 1 -> 0xF; 2,3 -> 0x0; 4..4+NUM_PADS-1 -> type of pad k (0x0 3-btn, 0x1 6-btn, 0xF absent).
REQ-015 After the type nibbles: data of present pads only, ascending order; 3-btn gives ~pad[3:0], ~pad[7:4]; 6-btn adds ~pad[11:8]; absent pads emit no data.
REQ-016 Data nibbles produced by a pad pointer + sub-nibble counter advanced with idx, not by a 2-D lookup; every idx beyond the last data nibble -> 0xF.
REQ-017 pads, pad_6btn, pad_present snapshotted into a frame buffer on rising TH; a frame never mixes two samples; snapshot not updated mid-frame.
REQ-018 Registered out = {hs_q[1], hs_q[0], hs_q[0], nibble(idx)}; TL echoes TR as acknowledge.
REQ-019 portN_out = (~portN_dir & portN_in) | (portN_dir & out), both ports, combinational.
REQ-020 Latency: hs change at tapped port reaches portN_out within 2 clk edges.
REQ-021 port_sel change mid-frame: idx=0 and snapshot reloaded on the next clk edge.

Reset
REQ-022 While reset_n=0: hs_q=2'b11, idx=0, pad pointer=0, timeout counter=0, snapshot=all buttons released, all pads absent, out=7'h73.
REQ-023 Deassertion takes effect on the first clk edge; first frame needs a rising TH.

Configuration
REQ-024 Macro MULTITAP_TIMEOUT_EN defined: 16-bit idle counter cleared on any hs change, +1 otherwise; on reaching TIMEOUT_CYCLES, idx=0 and pad pointer=0.
REQ-025 Macro undefined: no idle counter; idx only changes per REQ-013 and reset; TIMEOUT_CYCLES ignored.

Verification
REQ-026 NUM_PADS=4, all present 3-btn, port_sel=0, TH rise then 12 TR/TH toggles -> D = 3,F,0,0,0,0,0,0 then data of pads 1..4, each F,F with no buttons.
REQ-027 Pad 2 6-btn holding A+Z, pad 3 absent -> type nibbles 0,1,F,0; pad 2 data F,B,E; pad 4 data follows pad 2 directly.
REQ-028 port_sel=1, slot 4 holding UP -> first data nibble of tapped pad 4 = 0xE; port1 passes port1_in on undriven bits.
REQ-029 20 hs changes with 4 present 3-btn pads -> idx past end gives 0xF; next rising TH -> 0x3.
REQ-030 MULTITAP_TIMEOUT_EN, TIMEOUT_CYCLES=16: stop at idx 6, idle 16 clk -> D=0x3 without TH edge; without macro D holds.
REQ-031 reset_n low mid-frame at idx 9 -> port1_out on driven bits = 7'h73 asynchronously; frame restarts on next rising TH.
